// File: rtl/flash_link_pkg.sv
// Constants and state type shared by the flash reader, the packet framer and the UART top.
package flash_link_pkg;

  localparam logic [7:0] FLASH_SYNC_BYTE  = 8'hA5;
  localparam int         FLASH_ADDR_BYTES = 3;
  localparam int         FLASH_DATA_BYTES = 32;
  localparam int         FLASH_IN_W       = 8 * (FLASH_ADDR_BYTES + FLASH_DATA_BYTES);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_ADDR,
    ST_DATA,
    ST_CHK
  } framerState_e;

endpackage

// File: rtl/flash_packet_framer_if.sv
// Chunk input handshake (DA/RTR) and byte output stream for the packet framer.
interface flash_packet_framer_if import flash_link_pkg::*; #(
  parameter int IN_W = FLASH_IN_W
);
  logic [IN_W-1:0] in_data;
  logic            in_valid;
  logic            in_ready;
  logic [7:0]      tx_data;
  logic            tx_valid;
  logic            tx_ready;

  modport master (input in_data, in_valid, tx_ready, output in_ready, tx_data, tx_valid);
  modport slave  (output in_data, in_valid, tx_ready, input in_ready, tx_data, tx_valid);
endinterface

// File: rtl/flash_packet_framer.sv
// Frames each captured flash chunk as SYNC, address (MSB first), data (byte 0 first), checksum
// and streams it one byte per valid/ready transfer.
module flash_packet_framer import flash_link_pkg::*; #(
  parameter logic [7:0] SYNC_BYTE  = FLASH_SYNC_BYTE,
  parameter int         ADDR_BYTES = FLASH_ADDR_BYTES,
  parameter int         DATA_BYTES = FLASH_DATA_BYTES
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  flash_packet_framer_if.master bus,
  output logic                  busy,
  output logic [15:0]           pkt_count
);

  localparam int         IN_W      = 8 * (ADDR_BYTES + DATA_BYTES);
  localparam logic [5:0] ADDR_LAST = 6'(ADDR_BYTES - 1);
  localparam logic [5:0] DATA_LAST = 6'(DATA_BYTES - 1);

  framerState_e    state, stateNxt;
  logic [IN_W-1:0] capBuf;
  logic [5:0]      cnt, cntNxt;
  logic [7:0]      acc, accNxt, accSum;
  logic [7:0]      txData, txDataNxt;
  logic            txValid, txValidNxt;
  logic            inReady, inReadyNxt;
  logic [15:0]     pktCount, pktNxt;
  logic            capture, xfer;

  function automatic logic [7:0] pickByte(input logic [IN_W-1:0] b, input int lsb);
    return b[lsb +: 8];
  endfunction

  assign xfer   = txValid && bus.tx_ready;
  assign accSum = acc + txData;

  // The register holds the byte on the wire; the next byte is loaded on the same edge it transfers.
  always_comb begin
    stateNxt   = state;
    cntNxt     = cnt;
    accNxt     = acc;
    txDataNxt  = txData;
    txValidNxt = txValid;
    inReadyNxt = 1'b0;
    pktNxt     = pktCount;
    capture    = 1'b0;
    case (state)
      ST_IDLE: begin
        inReadyNxt = enable;
        if (bus.in_valid && inReady) begin
          capture    = 1'b1;
          inReadyNxt = 1'b0;
          accNxt     = 8'd0;
          cntNxt     = 6'd0;
          stateNxt   = ST_SYNC;
        end
      end
      ST_SYNC: begin
        if (!txValid) begin
          txValidNxt = 1'b1;
          txDataNxt  = SYNC_BYTE;
        end else if (xfer) begin
          stateNxt  = ST_ADDR;
          cntNxt    = 6'd0;
          txDataNxt = pickByte(capBuf, IN_W - 8);
        end
      end
      ST_ADDR: begin
        if (xfer) begin
          accNxt = accSum;
          if (cnt == ADDR_LAST) begin
            stateNxt  = ST_DATA;
            cntNxt    = 6'd0;
            txDataNxt = pickByte(capBuf, 0);
          end else begin
            cntNxt    = cnt + 6'd1;
            txDataNxt = pickByte(capBuf, IN_W - 8 - 8 * (int'(cnt) + 1));
          end
        end
      end
      ST_DATA: begin
        if (xfer) begin
          accNxt = accSum;
          if (cnt == DATA_LAST) begin
            stateNxt  = ST_CHK;
            cntNxt    = 6'd0;
            txDataNxt = 8'd0 - accSum;
          end else begin
            cntNxt    = cnt + 6'd1;
            txDataNxt = pickByte(capBuf, 8 * (int'(cnt) + 1));
          end
        end
      end
      ST_CHK: begin
        if (xfer) begin
          txValidNxt = 1'b0;
          pktNxt     = pktCount + 16'd1;
          cntNxt     = 6'd0;
          stateNxt   = ST_IDLE;
        end
      end
      default: stateNxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      capBuf   <= '0;
      cnt      <= 6'd0;
      acc      <= 8'd0;
      txData   <= 8'd0;
      txValid  <= 1'b0;
      inReady  <= 1'b0;
      pktCount <= 16'd0;
    end else begin
      state    <= stateNxt;
      cnt      <= cntNxt;
      acc      <= accNxt;
      txData   <= txDataNxt;
      txValid  <= txValidNxt;
      inReady  <= inReadyNxt;
      pktCount <= pktNxt;
      if (capture) capBuf <= bus.in_data;
    end
  end

  assign bus.in_ready = inReady;
  assign bus.tx_data  = txData;
  assign bus.tx_valid = txValid;
  assign busy         = (state != ST_IDLE);
  assign pkt_count    = pktCount;

endmodule
